// File: rtl/div_seq_32_pkg.sv
// Shared definitions for the 32-bit sequential signed divider.
//   WIDTH / STEPS    : data width and number of restoring steps
//   state_t          : divider FSM state encoding
//   FS_DIV           : ALU function-select code for division
//   INT_MIN, NEG_ONE : operands of the single overflowing division
//   abs_val()        : two's-complement magnitude (INT_MIN maps to 2**31)
package div_seq_32_pkg;

  localparam int WIDTH = 32;
  localparam int STEPS = WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [4:0]       FS_DIV  = 5'h1F;
  localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;
  localparam logic [WIDTH-1:0] NEG_ONE = 32'hFFFF_FFFF;

  // Result is read as unsigned, so |INT_MIN| = 0x80000000 is exact.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/div_seq_32_step.sv
// One restoring-division step, purely combinational.
//   rem, quo         : current partial remainder / quotient-dividend shift register
//   divisor          : divisor magnitude
//   rem_next, quo_next : {rem,quo} after shift, trial subtract and restore
module div_step_32
  import div_seq_32_pkg::*;
(
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem < divisor <= 2**31 always holds, so the 33-bit difference's MSB is
  // a reliable sign bit.
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor};

  always_comb begin
    rem_next = diff[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], 1'b1};
    if (diff[WIDTH]) begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq_32.sv
// 32-bit sequential signed divider (restoring, one quotient bit per clock).
//   clk, reset     : clock, asynchronous active-high reset
//   start, S, T    : request, dividend, divisor (sampled only when accepted in IDLE)
//   Y_hi, Y_lo     : remainder, quotient (held until the next result)
//   busy, done     : CALC indicator, one-cycle result-valid pulse
//   V, N, Z, DZ    : overflow, quotient sign, quotient zero, divide-by-zero
//
// state   | meaning
// IDLE    | waiting for start
// CALC    | 32 restoring steps in progress
// DONE    | results valid, done pulse
module div_seq_32
  import div_seq_32_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] T,
  output logic [WIDTH-1:0] Y_hi,
  output logic [WIDTH-1:0] Y_lo,
  output logic             busy,
  output logic             done,
  output logic             V,
  output logic             N,
  output logic             Z,
  output logic             DZ
);

  state_t           state, state_next;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] rem_r, quo_r, dvs_r;
  logic [WIDTH-1:0] rem_nx, quo_nx;
  logic             q_neg, r_neg;
  logic             is_dz, is_ov, last_step;

  assign is_dz     = (T == '0);
  assign is_ov     = (S == INT_MIN) && (T == NEG_ONE);
  assign last_step = (cnt == 5'(STEPS - 1));

  div_step_32 u_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .divisor  (dvs_r),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = (is_dz || is_ov) ? ST_DONE : ST_CALC;
      ST_CALC: if (last_step) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      rem_r <= '0;
      quo_r <= '0;
      dvs_r <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      Y_hi  <= '0;
      Y_lo  <= '0;
      V     <= 1'b0;
      DZ    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt   <= '0;
            rem_r <= '0;
            quo_r <= abs_val(S);
            dvs_r <= abs_val(T);
            q_neg <= S[WIDTH-1] ^ T[WIDTH-1];
            r_neg <= S[WIDTH-1];
            // Special cases finish immediately; normal results keep the
            // previous outputs until the last step.
            if (is_dz) begin
              Y_lo <= NEG_ONE;
              Y_hi <= S;
              DZ   <= 1'b1;
              V    <= 1'b0;
            end else if (is_ov) begin
              Y_lo <= INT_MIN;
              Y_hi <= '0;
              DZ   <= 1'b0;
              V    <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          rem_r <= rem_nx;
          quo_r <= quo_nx;
          cnt   <= cnt + 5'd1;
          if (last_step) begin
            Y_lo <= q_neg ? (~quo_nx + 1'b1) : quo_nx;
            Y_hi <= r_neg ? (~rem_nx + 1'b1) : rem_nx;
            V    <= 1'b0;
            DZ   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == ST_CALC);
  assign done = (state == ST_DONE);
  assign N    = Y_lo[WIDTH-1];
  assign Z    = ~|Y_lo;

endmodule

// File: tb/tb_div_seq_32.sv
module tb_div_seq_32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] S = '0;
  logic [31:0] T = '0;
  logic [31:0] Y_hi, Y_lo;
  logic        busy, done, V, N, Z, DZ;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_seq_32 dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .S     (S),
    .T     (T),
    .Y_hi  (Y_hi),
    .Y_lo  (Y_lo),
    .busy  (busy),
    .done  (done),
    .V     (V),
    .N     (N),
    .Z     (Z),
    .DZ    (DZ)
  );

  // Reference: C-style signed division (truncate toward zero, remainder
  // takes the dividend's sign) plus the two defined special cases.
  function automatic void model(input logic [31:0] s, input logic [31:0] t,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic v, output logic dz, output int lat);
    int si, ti;
    si = s;
    ti = t;
    v  = 1'b0;
    dz = 1'b0;
    if (t == 32'd0) begin
      q = 32'hFFFF_FFFF; r = s; dz = 1'b1; lat = 1;
    end else if (s == 32'h8000_0000 && t == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; v = 1'b1; lat = 1;
    end else begin
      q = si / ti; r = si % ti; lat = 33;
    end
  endfunction

  task automatic run_div(input logic [31:0] s_in, input logic [31:0] t_in);
    logic [31:0] eq, er;
    logic ev, edz;
    int elat, waited;
    model(s_in, t_in, eq, er, ev, edz, elat);
    @(negedge clk);
    S = s_in; T = t_in; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    S = $urandom; T = $urandom;
    waited = 1;
    while (!done && waited < 40) begin
      if (!busy) begin
        errors++;
        $display("FAIL busy_low s=%h t=%h cycle=%0d busy=%b required 1", s_in, t_in, waited, busy);
      end
      @(negedge clk);
      S = $urandom; T = $urandom;
      waited++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout s=%h t=%h no done within %0d cycles", s_in, t_in, waited);
      return;
    end
    checks++;
    if (waited !== elat) begin
      errors++;
      $display("FAIL latency s=%h t=%h got %0d required %0d", s_in, t_in, waited, elat);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_with_done s=%h t=%h busy=%b required 0", s_in, t_in, busy);
    end
    checks++;
    if (Y_lo !== eq) begin
      errors++;
      $display("FAIL quotient s=%h t=%h got %h required %h", s_in, t_in, Y_lo, eq);
    end
    checks++;
    if (Y_hi !== er) begin
      errors++;
      $display("FAIL remainder s=%h t=%h got %h required %h", s_in, t_in, Y_hi, er);
    end
    checks++;
    if ({V, DZ, N, Z} !== {ev, edz, eq[31], (eq == 32'd0)}) begin
      errors++;
      $display("FAIL flags s=%h t=%h got VDZNZ=%b%b%b%b required %b%b%b%b",
               s_in, t_in, V, DZ, N, Z, ev, edz, eq[31], (eq == 32'd0));
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width s=%h t=%h done=%b required 0", s_in, t_in, done);
    end
    checks++;
    if (Y_lo !== eq || Y_hi !== er || V !== ev || DZ !== edz) begin
      errors++;
      $display("FAIL result_hold s=%h t=%h got %h/%h required %h/%h", s_in, t_in, Y_lo, Y_hi, eq, er);
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({Y_hi, Y_lo} !== 64'd0 || {busy, done, V, N, Z, DZ} !== 6'b000010) begin
      errors++;
      $display("FAIL %s got Y=%h/%h bdVNZDZ=%b%b%b%b%b%b required 0/0 000010",
               tag, Y_hi, Y_lo, busy, done, V, N, Z, DZ);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset_state");
    reset = 1'b0;
  endtask

  task automatic test_directed();
    run_div(32'd100, 32'd7);
    run_div(32'hFFFF_FF9C, 32'd7);
    run_div(32'd5, 32'd0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF);
    run_div(32'h8000_0000, 32'd1);
    run_div(32'h8000_0000, 32'h8000_0000);
    run_div(32'h7FFF_FFFF, 32'hFFFF_FFFF);
    run_div(32'd0, 32'hFFFF_FFF9);
    run_div(32'h8000_0000, 32'd0);
  endtask

  task automatic test_random();
    logic [31:0] s, t;
    for (int i = 0; i < 30; i++) begin
      s = $urandom;
      case ($urandom_range(0, 4))
        0: t = $urandom;
        1: t = $urandom_range(1, 20);
        2: t = -$urandom_range(1, 20);
        3: t = 32'd0;
        default: t = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 5) == 0) s = 32'h8000_0000;
      run_div(s, t);
    end
  endtask

  task automatic test_ignore_start();
    int pulses;
    @(negedge clk);
    S = 32'd3; T = 32'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 45; c++) begin
      if (done) pulses++;
      if (c == 10) begin
        S = 32'd50; T = 32'd5; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL ignore_start_pulses got %0d required 1", pulses);
    end
    checks++;
    if (Y_lo !== 32'd0 || Y_hi !== 32'd3 || Z !== 1'b1) begin
      errors++;
      $display("FAIL ignore_start_result got %h/%h Z=%b required 00000000/00000003 Z=1", Y_lo, Y_hi, Z);
    end
  endtask

  task automatic test_reset_abort();
    int pulses;
    run_div(32'd1000, 32'd3);
    @(negedge clk);
    S = 32'd12345; T = 32'd11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy_before_reset got %b required 1", busy);
    end
    reset = 1'b1;
    #1;
    check_reset_values("reset_abort_async");
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (done || busy) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL abort_no_done got %0d active cycles required 0", pulses);
    end
    run_div(32'd81, 32'd9);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) run_div($urandom, $urandom_range(1, 1000));
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
